flag_stack: RTL and testbench
=============================

Name: flag_stack

Overview:
- Status-flag stage directly downstream of the 16-bit ALU in the single-cycle CPU.
- Registers the ALU carry, overflow and zero outputs under control-unit enable.
- Saves and restores the flag word on a small LIFO for interrupt entry and return.
- Evaluates the jump condition for the control unit from the registered flags.

Parameters:
- DEPTH, 4, number of LIFO entries (power of two, 2..16)
- PTR_W, $clog2(DEPTH), LIFO index width (derived; not overridden)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous reset, active-low
- carry_in  in  1  ALU carry
- overflow_in  in  1  ALU overflow
- zero_in  in  1  ALU zero
- we_flags  in  1  load ALU flags into the flag register this cycle
- push  in  1  save the current flag word to the LIFO (interrupt entry)
- pop  in  1  restore the flag word from the LIFO (interrupt return)
- err_clr  in  1  clear sticky stack_err
- cond_sel  in  3  jump-condition select
- flags_out  out  3  registered {carry, overflow, zero}
- cond_true  out  1  selected condition evaluated on flags_out
- depth  out  PTR_W+1  occupied LIFO entries, 0..DEPTH
- full  out  1  depth == DEPTH
- empty  out  1  depth == 0
- stack_err  out  1  sticky push-when-full / pop-when-empty / push+pop error

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low.
- While reset==0 at an edge: flags_out=000, depth=0, empty=1, full=0, stack_err=0. LIFO contents are don't-care and need no reset.
- full, empty and depth are registered-state decodes: full = (depth==DEPTH), empty = (depth==0).
- Latency: flags_out, depth and stack_err change one edge after the request. cond_true is combinational from flags_out and cond_sel, with no added delay.
- Per-edge priority, with F = current flags_out:
  1. push=1 and pop=1: stack and depth unchanged; stack_err<=1. If we_flags=1, flags<=ALU flags.
  2. pop=1, depth>0: flags<=LIFO[depth-1]; depth<=depth-1. we_flags is ignored (restore wins).
  3. pop=1, depth==0: stack unchanged; stack_err<=1. If we_flags=1, flags<=ALU flags.
  4. push=1, depth<DEPTH: LIFO[depth]<=F (pre-update value); depth<=depth+1. If we_flags=1, flags<=ALU flags in the same edge. The pushed value is always the old F.
  5. push=1, depth==DEPTH: entry dropped; depth stays DEPTH; stack_err<=1. If we_flags=1, flags<=ALU flags.
  6. Otherwise: if we_flags=1, flags<=ALU flags; else hold.
- err_clr=1 clears stack_err unless an error is raised in the same edge; a same-edge error wins.
- No wrap-around: the index never exceeds DEPTH-1, and depth saturates at both 0 and DEPTH.
- cond_sel decode:
  - 000 always (1)
  - 001 Z
  - 010 !Z
  - 011 C
  - 100 !C
  - 101 O
  - 110 !O
  - 111 never (0)
- Reset asserted mid-sequence (any depth) empties the stack on that edge; the LIFO holds no valid entries afterward.

Decomposition:
- Shared include flag_defs.vh holds:
  - flag bit indices: FLAG_C=2, FLAG_O=1, FLAG_Z=0
  - the eight COND_* 3-bit codes
- Both are shared with the control unit, which drives cond_sel.
- One sub-module, flag_lifo: DEPTH x 3 storage array plus depth counter and full/empty decode.
- The top level holds the flag register, priority logic, the sticky error and the condition mux.

Test Plan:
1. Reset, then we_flags with c/o/z = 1/0/1 -> next edge flags_out=101. cond_sel=001 gives 1; cond_sel=011 gives 1; cond_sel=101 gives 0. depth=0, empty=1.
2. flags=101; push with we_flags and ALU flags 010 -> flags_out=010, depth=1. Then pop -> flags_out=101, depth=0, stack_err=0.
3. DEPTH=4: push 5 times with flags 001, 010, 011, 100, 111 (loaded between pushes) -> after the 4th push full=1. The 5th push gives stack_err=1, depth=4. Four pops return 100, 011, 010, 001 in order; then empty=1.
4. Pop at depth=0 with we_flags and ALU flags 110 -> flags_out=110, depth=0, stack_err=1. err_clr next cycle -> stack_err=0.
5. push and pop in the same cycle at depth=2 -> depth stays 2, stack_err=1. Pop with we_flags at depth=1 -> flags restored from the LIFO, ALU input ignored.
6. Reset driven low at depth=3 with flags_out=111 -> next edge flags_out=000, depth=0, empty=1. A subsequent pop sets stack_err=1.

Source files
------------

// File: rtl/flag_stack_pkg.sv
// Shared definitions for the flag stage: flag bit positions, jump-condition
// codes (also imported by the control unit that drives cond_sel), the
// internal stack-operation encoding and the condition evaluator.
package flag_stack_pkg;

  // Bit positions inside the 3-bit flag word {carry, overflow, zero}
  localparam int FLAG_C = 2;
  localparam int FLAG_O = 1;
  localparam int FLAG_Z = 0;

  // Jump-condition select codes
  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_Z      = 3'b001;
  localparam logic [2:0] COND_NZ     = 3'b010;
  localparam logic [2:0] COND_C      = 3'b011;
  localparam logic [2:0] COND_NC     = 3'b100;
  localparam logic [2:0] COND_O      = 3'b101;
  localparam logic [2:0] COND_NO     = 3'b110;
  localparam logic [2:0] COND_NEVER  = 3'b111;

  // What the stack does on a given edge once the request priority is resolved
  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_SAVE    = 2'd1,
    OP_RESTORE = 2'd2,
    OP_ERROR   = 2'd3
  } stack_op_e;

  // Evaluate a jump condition against a flag word
  function automatic logic cond_eval(input logic [2:0] flags, input logic [2:0] sel);
    logic result;
    result = 1'b0;
    case (sel)
      COND_ALWAYS: result = 1'b1;
      COND_Z:      result = flags[FLAG_Z];
      COND_NZ:     result = !flags[FLAG_Z];
      COND_C:      result = flags[FLAG_C];
      COND_NC:     result = !flags[FLAG_C];
      COND_O:      result = flags[FLAG_O];
      COND_NO:     result = !flags[FLAG_O];
      COND_NEVER:  result = 1'b0;
      default:     result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/flag_stack_lifo.sv
// flag_lifo: DEPTH x 3-bit save area for the flag word with an occupancy
// counter. The counter saturates at 0 and DEPTH; requests that would
// underflow/overflow, or a simultaneous push and pop, leave it untouched.
module flag_lifo
  import flag_stack_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_en,
  input  logic             pop_en,
  input  logic [2:0]       push_data,
  output logic [2:0]       top_data,
  output logic [PTR_W:0]   depth,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] MAX_COUNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W:0]   count_q;
  logic [2:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;
  logic             do_push;
  logic             do_pop;

  // Next free slot is the low bits of the count; the top entry is one below.
  // At count==DEPTH the low bits are zero, so rd_idx wraps to DEPTH-1 as wanted.
  assign wr_idx   = count_q[PTR_W-1:0];
  assign rd_idx   = count_q[PTR_W-1:0] - PTR_W'(1);
  assign full     = (count_q == MAX_COUNT);
  assign empty    = (count_q == '0);
  assign depth    = count_q;
  assign top_data = mem[rd_idx];

  // Only act on legal, unambiguous requests so the index never leaves range
  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    if (push_en && !pop_en && !full) do_push = 1'b1;
    if (pop_en && !push_en && !empty) do_pop = 1'b1;
  end

  // Occupancy counter; reset empties the stack
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (do_push) begin
      count_q <= count_q + 1'b1;
    end else if (do_pop) begin
      count_q <= count_q - 1'b1;
    end
  end

  // Storage array; contents are meaningless below the counter so no reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/flag_stack.sv
// flag_stack: registers ALU {carry, overflow, zero}, saves/restores the flag
// word on a small LIFO for interrupt entry/return, keeps a sticky stack
// error and evaluates the jump condition for the control unit.
module flag_stack
  import flag_stack_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           carry_in,
  input  logic           overflow_in,
  input  logic           zero_in,
  input  logic           we_flags,
  input  logic           push,
  input  logic           pop,
  input  logic           err_clr,
  input  logic [2:0]     cond_sel,
  output logic [2:0]     flags_out,
  output logic           cond_true,
  output logic [PTR_W:0] depth,
  output logic           full,
  output logic           empty,
  output logic           stack_err
);

  logic [2:0] flags_q;
  logic [2:0] flags_d;
  logic       err_q;
  logic       err_d;
  logic [2:0] alu_flags;
  logic [2:0] top_data;
  stack_op_e  op;

  assign alu_flags = {carry_in, overflow_in, zero_in};

  flag_lifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_lifo (
    .clk       (clk),
    .reset     (reset),
    .push_en   (op == OP_SAVE),
    .pop_en    (op == OP_RESTORE),
    .push_data (flags_q),
    .top_data  (top_data),
    .depth     (depth),
    .full      (full),
    .empty     (empty)
  );

  // Resolve push/pop requests into a single stack operation for this edge
  always_comb begin
    op = OP_NONE;
    if (push && pop) begin
      op = OP_ERROR;
    end else if (pop) begin
      op = empty ? OP_ERROR : OP_RESTORE;
    end else if (push) begin
      op = full ? OP_ERROR : OP_SAVE;
    end
  end

  // Next flag word: a restore beats an ALU load, otherwise load or hold.
  // A save pushes the current register value, so a same-edge load is safe.
  always_comb begin
    flags_d = flags_q;
    if (op == OP_RESTORE) begin
      flags_d = top_data;
    end else if (we_flags) begin
      flags_d = alu_flags;
    end
  end

  // Sticky error: a new error on this edge outranks a clear request
  always_comb begin
    err_d = err_q;
    if (op == OP_ERROR) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // Flag register and sticky error state
  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_q <= 3'b000;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  // Jump condition is purely combinational from the registered flags
  always_comb begin
    cond_true = cond_eval(flags_q, cond_sel);
  end

  assign flags_out = flags_q;
  assign stack_err = err_q;

endmodule

// File: tb/tb_flag_stack.sv
// Self-checking bench for flag_stack: directed scenarios with constant
// expectations, then randomized traffic against a queue-based model.
module tb_flag_stack;

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  logic           clk;
  logic           reset;
  logic           carry_in;
  logic           overflow_in;
  logic           zero_in;
  logic           we_flags;
  logic           push;
  logic           pop;
  logic           err_clr;
  logic [2:0]     cond_sel;
  logic [2:0]     flags_out;
  logic           cond_true;
  logic [PTR_W:0] depth;
  logic           full;
  logic           empty;
  logic           stack_err;

  int n_compared;
  int n_mismatched;

  // Reference model state
  logic [2:0] m_flags;
  logic [2:0] m_stack[$];
  logic       m_err;

  flag_stack #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .carry_in    (carry_in),
    .overflow_in (overflow_in),
    .zero_in     (zero_in),
    .we_flags    (we_flags),
    .push        (push),
    .pop         (pop),
    .err_clr     (err_clr),
    .cond_sel    (cond_sel),
    .flags_out   (flags_out),
    .cond_true   (cond_true),
    .depth       (depth),
    .full        (full),
    .empty       (empty),
    .stack_err   (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Condition table written directly from the decode list
  function automatic logic model_cond(input logic [2:0] f, input logic [2:0] sel);
    logic c, o, z;
    c = f[2]; o = f[1]; z = f[0];
    case (sel)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return c;
      3'd4: return !c;
      3'd5: return o;
      3'd6: return !o;
      default: return 1'b0;
    endcase
  endfunction

  // Apply one edge worth of request rules to the model
  task automatic model_step(input logic rst_n, input logic [2:0] alu, input logic we,
                            input logic ps, input logic pp, input logic clr);
    logic e;
    e = 1'b0;
    if (!rst_n) begin
      m_flags = 3'b000;
      m_stack.delete();
      m_err = 1'b0;
    end else begin
      if (ps && pp) begin
        e = 1'b1;
        if (we) m_flags = alu;
      end else if (pp) begin
        if (m_stack.size() > 0) m_flags = m_stack.pop_back();
        else begin
          e = 1'b1;
          if (we) m_flags = alu;
        end
      end else if (ps) begin
        if (m_stack.size() < DEPTH) m_stack.push_back(m_flags);
        else e = 1'b1;
        if (we) m_flags = alu;
      end else if (we) begin
        m_flags = alu;
      end
      if (e) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, advance the model, then settle after the edge
  task automatic cycle(input logic rst_n, input logic [2:0] alu, input logic we,
                       input logic ps, input logic pp, input logic clr);
    reset       = rst_n;
    carry_in    = alu[2];
    overflow_in = alu[1];
    zero_in     = alu[0];
    we_flags    = we;
    push        = ps;
    pop         = pp;
    err_clr     = clr;
    model_step(rst_n, alu, we, ps, pp, clr);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    we_flags = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    err_clr  = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
    n_compared += 5;
    if (flags_out !== 3'b000) begin n_mismatched++; $display("[TB] FAIL reset_flags got=%b want=000", flags_out); end
    if (depth !== 3'd0) begin n_mismatched++; $display("[TB] FAIL reset_depth got=%0d want=0", depth); end
    if (empty !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_empty got=%b want=1", empty); end
    if (full !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_full got=%b want=0", full); end
    if (stack_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_err got=%b want=0", stack_err); end
  endtask

  task automatic test_load_and_cond();
    logic [2:0] exp_c [8];
    exp_c = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    cycle(1'b1, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0);
    n_compared += 3;
    if (flags_out !== 3'b101) begin n_mismatched++; $display("[TB] FAIL load_flags got=%b want=101", flags_out); end
    if (depth !== 3'd0) begin n_mismatched++; $display("[TB] FAIL load_depth got=%0d want=0", depth); end
    if (empty !== 1'b1) begin n_mismatched++; $display("[TB] FAIL load_empty got=%b want=1", empty); end
    for (int s = 0; s < 8; s++) begin
      cond_sel = 3'(s);
      #1;
      n_compared++;
      if (cond_true !== exp_c[s][0]) begin
        n_mismatched++;
        $display("[TB] FAIL cond_sel_%0d got=%b want=%b", s, cond_true, exp_c[s][0]);
      end
    end
  endtask

  task automatic test_push_pop();
    cycle(1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0);
    n_compared += 2;
    if (flags_out !== 3'b010) begin n_mismatched++; $display("[TB] FAIL pushload_flags got=%b want=010", flags_out); end
    if (depth !== 3'd1) begin n_mismatched++; $display("[TB] FAIL pushload_depth got=%0d want=1", depth); end
    cycle(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    n_compared += 3;
    if (flags_out !== 3'b101) begin n_mismatched++; $display("[TB] FAIL pop_flags got=%b want=101", flags_out); end
    if (depth !== 3'd0) begin n_mismatched++; $display("[TB] FAIL pop_depth got=%0d want=0", depth); end
    if (stack_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL pop_err got=%b want=0", stack_err); end
  endtask

  task automatic test_fill_overflow();
    logic [2:0] loads [5];
    logic [2:0] pops [4];
    loads = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
    pops  = '{3'b100, 3'b011, 3'b010, 3'b001};
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, loads[i], 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
      if (i == 3) begin
        n_compared += 2;
        if (full !== 1'b1) begin n_mismatched++; $display("[TB] FAIL fill_full got=%b want=1", full); end
        if (stack_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL fill_err got=%b want=0", stack_err); end
      end
    end
    n_compared += 2;
    if (stack_err !== 1'b1) begin n_mismatched++; $display("[TB] FAIL overflow_err got=%b want=1", stack_err); end
    if (depth !== 3'd4) begin n_mismatched++; $display("[TB] FAIL overflow_depth got=%0d want=4", depth); end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
      n_compared++;
      if (flags_out !== pops[i]) begin
        n_mismatched++;
        $display("[TB] FAIL drain_%0d got=%b want=%b", i, flags_out, pops[i]);
      end
    end
    n_compared++;
    if (empty !== 1'b1) begin n_mismatched++; $display("[TB] FAIL drain_empty got=%b want=1", empty); end
  endtask

  task automatic test_pop_empty();
    cycle(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 3'b110, 1'b1, 1'b0, 1'b1, 1'b0);
    n_compared += 3;
    if (flags_out !== 3'b110) begin n_mismatched++; $display("[TB] FAIL popempty_flags got=%b want=110", flags_out); end
    if (depth !== 3'd0) begin n_mismatched++; $display("[TB] FAIL popempty_depth got=%0d want=0", depth); end
    if (stack_err !== 1'b1) begin n_mismatched++; $display("[TB] FAIL popempty_err got=%b want=1", stack_err); end
    cycle(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    n_compared++;
    if (stack_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL errclr got=%b want=0", stack_err); end
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 3'b101, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1);
    n_compared += 2;
    if (depth !== 3'd2) begin n_mismatched++; $display("[TB] FAIL pushpop_depth got=%0d want=2", depth); end
    if (stack_err !== 1'b1) begin n_mismatched++; $display("[TB] FAIL pushpop_err got=%b want=1", stack_err); end
    cycle(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    n_compared++;
    if (flags_out !== 3'b101) begin n_mismatched++; $display("[TB] FAIL pop2_flags got=%b want=101", flags_out); end
    cycle(1'b1, 3'b110, 1'b1, 1'b0, 1'b1, 1'b0);
    n_compared += 2;
    if (flags_out !== 3'b011) begin n_mismatched++; $display("[TB] FAIL popwe_flags got=%b want=011", flags_out); end
    if (depth !== 3'd0) begin n_mismatched++; $display("[TB] FAIL popwe_depth got=%0d want=0", depth); end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0);
    n_compared += 2;
    if (depth !== 3'd3) begin n_mismatched++; $display("[TB] FAIL premid_depth got=%0d want=3", depth); end
    if (flags_out !== 3'b111) begin n_mismatched++; $display("[TB] FAIL premid_flags got=%b want=111", flags_out); end
    cycle(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    n_compared += 3;
    if (flags_out !== 3'b000) begin n_mismatched++; $display("[TB] FAIL midrst_flags got=%b want=000", flags_out); end
    if (depth !== 3'd0) begin n_mismatched++; $display("[TB] FAIL midrst_depth got=%0d want=0", depth); end
    if (empty !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midrst_empty got=%b want=1", empty); end
    cycle(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    n_compared += 2;
    if (stack_err !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midrst_pop_err got=%b want=1", stack_err); end
    if (flags_out !== 3'b000) begin n_mismatched++; $display("[TB] FAIL midrst_pop_flags got=%b want=000", flags_out); end
  endtask

  task automatic test_random();
    logic       rn, we, ps, pp, clr;
    logic [2:0] alu;
    for (int i = 0; i < 400; i++) begin
      rn  = ($urandom_range(0, 49) != 0);
      we  = 1'($urandom_range(0, 1));
      ps  = ($urandom_range(0, 2) == 0);
      pp  = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 7) == 0);
      alu = 3'($urandom_range(0, 7));
      cond_sel = 3'($urandom_range(0, 7));
      cycle(rn, alu, we, ps, pp, clr);
      n_compared += 6;
      if (flags_out !== m_flags) begin n_mismatched++; $display("[TB] FAIL rnd%0d_flags got=%b want=%b", i, flags_out, m_flags); end
      if (depth !== 3'(m_stack.size())) begin n_mismatched++; $display("[TB] FAIL rnd%0d_depth got=%0d want=%0d", i, depth, m_stack.size()); end
      if (full !== (m_stack.size() == DEPTH)) begin n_mismatched++; $display("[TB] FAIL rnd%0d_full got=%b", i, full); end
      if (empty !== (m_stack.size() == 0)) begin n_mismatched++; $display("[TB] FAIL rnd%0d_empty got=%b", i, empty); end
      if (stack_err !== m_err) begin n_mismatched++; $display("[TB] FAIL rnd%0d_err got=%b want=%b", i, stack_err, m_err); end
      if (cond_true !== model_cond(m_flags, cond_sel)) begin
        n_mismatched++;
        $display("[TB] FAIL rnd%0d_cond got=%b want=%b", i, cond_true, model_cond(m_flags, cond_sel));
      end
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    m_flags      = 3'b000;
    m_err        = 1'b0;
    reset        = 1'b0;
    carry_in     = 1'b0;
    overflow_in  = 1'b0;
    zero_in      = 1'b0;
    we_flags     = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    err_clr      = 1'b0;
    cond_sel     = 3'b000;
    test_reset();
    test_load_and_cond();
    test_push_pop();
    test_fill_overflow();
    test_pop_empty();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
